// File: rtl/fb_pkg.sv
// ============================================================================
// Module      : fb_pkg
// Description : Shared widths and state encoding for the framebuffer write path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fb_pkg;

  localparam int FB_ADDR_W = 16;
  localparam int FB_DATA_W = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fb_arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter; on a tie the requester not
//               granted most recently wins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  input  logic       upd,
  output logic [1:0] gnt
);

  logic r_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (upd && en && (gnt != 2'b00)) begin
      r_last <= gnt[1];
    end
  end

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = r_last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/fb_write_arbiter.sv
// ============================================================================
// Module      : fb_write_arbiter
// Description : Shares the framebuffer write port between two requesters and
//               a range-clear sequencer. Define FB_VBLANK_ONLY_EN to restrict
//               writes to vertical blanking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_write_arbiter
  import fb_pkg::*;
#(
  parameter int          ADDR_W     = FB_ADDR_W,
  parameter int          DATA_W     = FB_DATA_W,
  parameter int unsigned CLEAR_LAST = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              clear_start,
  input  logic [DATA_W-1:0] clear_value,
  output logic              clear_busy,
  input  logic              vblank,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [DATA_W-1:0] fb_data
);

  localparam logic [ADDR_W-1:0] c_clear_last = CLEAR_LAST[ADDR_W-1:0];

  fb_arb_state_t     r_state;
  fb_arb_state_t     w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_clear_val;
  logic              r_fb_we;
  logic [ADDR_W-1:0] r_fb_addr;
  logic [DATA_W-1:0] r_fb_data;
  logic              w_elig;
  logic              w_arb_en;
  logic [1:0]        w_gnt;
  logic              w_clear_wr;

`ifdef FB_VBLANK_ONLY_EN
  assign w_elig = vblank;
`else
  logic w_unused_vblank;
  assign w_unused_vblank = vblank;
  assign w_elig          = 1'b1;
`endif

  // Gating with rst_n keeps both grants low while reset is held.
  assign w_arb_en   = rst_n && (r_state == IDLE) && w_elig;
  assign w_clear_wr = (r_state == CLEAR) && w_elig;

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({req1_valid, req0_valid}),
    .en    (w_arb_en),
    .upd   (1'b1),
    .gnt   (w_gnt)
  );

  assign req0_ready = w_gnt[0];
  assign req1_ready = w_gnt[1];
  assign clear_busy = (r_state == CLEAR);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (clear_start) w_state_nxt = CLEAR;
      CLEAR:   if (w_clear_wr && (r_cnt == c_clear_last)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_clear_val <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == IDLE) && clear_start) begin
        r_clear_val <= clear_value;
        r_cnt       <= '0;
      end else if (w_clear_wr) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Address and data hold their last value whenever no write is issued.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fb_we   <= 1'b0;
      r_fb_addr <= '0;
      r_fb_data <= '0;
    end else begin
      r_fb_we <= 1'b0;
      if (w_gnt[0]) begin
        r_fb_we   <= 1'b1;
        r_fb_addr <= req0_addr;
        r_fb_data <= req0_data;
      end else if (w_gnt[1]) begin
        r_fb_we   <= 1'b1;
        r_fb_addr <= req1_addr;
        r_fb_data <= req1_data;
      end else if (w_clear_wr) begin
        r_fb_we   <= 1'b1;
        r_fb_addr <= r_cnt;
        r_fb_data <= r_clear_val;
      end
    end
  end

  assign fb_we   = r_fb_we;
  assign fb_addr = r_fb_addr;
  assign fb_data = r_fb_data;

endmodule

`default_nettype wire

// File: tb/tb_fb_write_arbiter.sv
// ============================================================================
// Module      : tb_fb_write_arbiter
// Description : Directed self-checking bench for fb_write_arbiter (CLEAR_LAST=15).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fb_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_addr, req1_addr;
  logic [7:0]  req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        clear_start;
  logic [7:0]  clear_value;
  logic        clear_busy;
  logic        vblank;
  logic        fb_we;
  logic [15:0] fb_addr;
  logic [7:0]  fb_data;

  int n_tests;
  int n_fail;

  fb_write_arbiter #(
    .ADDR_W     (16),
    .DATA_W     (8),
    .CLEAR_LAST (15)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_addr   (req0_addr),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_addr   (req1_addr),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .clear_start (clear_start),
    .clear_value (clear_value),
    .clear_busy  (clear_busy),
    .vblank      (vblank),
    .fb_we       (fb_we),
    .fb_addr     (fb_addr),
    .fb_data     (fb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and land 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid  = 1'b0;
    req1_valid  = 1'b0;
    req0_addr   = 16'h0;
    req1_addr   = 16'h0;
    req0_data   = 8'h0;
    req1_data   = 8'h0;
    clear_start = 1'b0;
    clear_value = 8'h0;
    vblank      = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n      = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_addr  = 16'h1111;
    req0_data  = 8'h11;
    tick();
    tick();
    n_tests++;
    if (fb_we !== 1'b0) begin n_fail++; $display("FAIL reset_fb_we got %b exp 0", fb_we); end
    n_tests++;
    if (fb_addr !== 16'h0) begin n_fail++; $display("FAIL reset_fb_addr got %h exp 0000", fb_addr); end
    n_tests++;
    if (fb_data !== 8'h0) begin n_fail++; $display("FAIL reset_fb_data got %h exp 00", fb_data); end
    n_tests++;
    if (clear_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", clear_busy); end
    n_tests++;
    if ({req1_ready, req0_ready} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ready got %b exp 00", {req1_ready, req0_ready});
    end
    idle_inputs();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    req0_valid = 1'b1;
    req0_addr  = 16'h0010;
    req0_data  = 8'hA5;
    #1;
    n_tests++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      n_fail++; $display("FAIL single_ready got %b exp 01", {req1_ready, req0_ready});
    end
    tick();
    req0_valid = 1'b0;
    n_tests++;
    if ({fb_we, fb_addr, fb_data} !== {1'b1, 16'h0010, 8'hA5}) begin
      n_fail++; $display("FAIL single_write got we=%b a=%h d=%h exp we=1 a=0010 d=a5", fb_we, fb_addr, fb_data);
    end
    tick();
    n_tests++;
    if ({fb_we, fb_addr, fb_data} !== {1'b0, 16'h0010, 8'hA5}) begin
      n_fail++; $display("FAIL single_hold got we=%b a=%h d=%h exp we=0 a=0010 d=a5", fb_we, fb_addr, fb_data);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    req0_valid = 1'b1; req0_addr = 16'h0100; req0_data = 8'h11;
    req1_valid = 1'b1; req1_addr = 16'h0200; req1_data = 8'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++;
      if ({req1_ready, req0_ready} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        n_fail++; $display("FAIL rr_grant[%0d] got %b exp %b", i, {req1_ready, req0_ready},
                           (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      tick();
      n_tests++;
      if ({fb_we, fb_addr} !== {1'b1, ((i % 2 == 0) ? 16'h0100 : 16'h0200)}) begin
        n_fail++; $display("FAIL rr_write[%0d] got we=%b a=%h exp alternating 0100/0200", i, fb_we, fb_addr);
      end
    end
    // Only req1 valid with last pointing at req1: it must still win.
    req0_valid = 1'b0;
    #1;
    n_tests++;
    if ({req1_ready, req0_ready} !== 2'b10) begin
      n_fail++; $display("FAIL rr_single_req1 got %b exp 10", {req1_ready, req0_ready});
    end
    tick();
    req1_valid = 1'b0;
    n_tests++;
    if ({fb_we, fb_addr, fb_data} !== {1'b1, 16'h0200, 8'h22}) begin
      n_fail++; $display("FAIL rr_single_write got we=%b a=%h d=%h exp we=1 a=0200 d=22", fb_we, fb_addr, fb_data);
    end
  endtask

  task automatic test_clear();
    int wr_cnt;
    do_reset();
    clear_start = 1'b1;
    clear_value = 8'h3C;
    req1_valid  = 1'b1; req1_addr = 16'h0055; req1_data = 8'h77;
    #1;
    n_tests++;
    if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL clear_start_arb got %b exp 1", req1_ready); end
    tick();
    clear_start = 1'b0;
    clear_value = 8'h00;
    req1_valid  = 1'b0;
    req0_valid  = 1'b1; req0_addr = 16'h0099; req0_data = 8'h42;
    n_tests++;
    if ({fb_we, fb_addr, fb_data} !== {1'b1, 16'h0055, 8'h77}) begin
      n_fail++; $display("FAIL clear_start_write got we=%b a=%h d=%h exp we=1 a=0055 d=77", fb_we, fb_addr, fb_data);
    end
    wr_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      #1;
      n_tests++;
      if ({clear_busy, req0_ready, req1_ready} !== 3'b100) begin
        n_fail++; $display("FAIL clear_busy_stall[%0d] got %b exp 100", k, {clear_busy, req0_ready, req1_ready});
      end
      if (k == 5) begin
        clear_start = 1'b1;
        clear_value = 8'hEE;
      end
      tick();
      clear_start = 1'b0;
      if (fb_we === 1'b1) wr_cnt++;
      n_tests++;
      if ({fb_we, fb_addr, fb_data} !== {1'b1, k[15:0], 8'h3C}) begin
        n_fail++; $display("FAIL clear_write[%0d] got we=%b a=%h d=%h exp we=1 a=%h d=3c", k, fb_we, fb_addr, fb_data, k[15:0]);
      end
    end
    n_tests++;
    if (wr_cnt != 16) begin n_fail++; $display("FAIL clear_count got %0d exp 16", wr_cnt); end
    #1;
    n_tests++;
    if ({clear_busy, req0_ready} !== 2'b01) begin
      n_fail++; $display("FAIL clear_done got busy/ready %b exp 01", {clear_busy, req0_ready});
    end
    tick();
    req0_valid = 1'b0;
    n_tests++;
    if ({fb_we, fb_addr, fb_data} !== {1'b1, 16'h0099, 8'h42}) begin
      n_fail++; $display("FAIL clear_after_req0 got we=%b a=%h d=%h exp we=1 a=0099 d=42", fb_we, fb_addr, fb_data);
    end
    tick();
    n_tests++;
    if ({fb_we, clear_busy} !== 2'b00) begin
      n_fail++; $display("FAIL clear_no_extra got we/busy %b exp 00", {fb_we, clear_busy});
    end
  endtask

  task automatic test_reset_mid_clear();
    do_reset();
    clear_start = 1'b1;
    clear_value = 8'h5A;
    tick();
    clear_start = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    rst_n = 1'b0;
    tick();
    n_tests++;
    if ({clear_busy, fb_we} !== 2'b00) begin
      n_fail++; $display("FAIL midclr_reset got busy/we %b exp 00", {clear_busy, fb_we});
    end
    rst_n = 1'b1;
    tick();
    n_tests++;
    if ({clear_busy, fb_we} !== 2'b00) begin
      n_fail++; $display("FAIL midclr_residual got busy/we %b exp 00", {clear_busy, fb_we});
    end
    clear_start = 1'b1;
    clear_value = 8'h81;
    tick();
    clear_start = 1'b0;
    tick();
    n_tests++;
    if ({fb_we, fb_addr, fb_data} !== {1'b1, 16'h0000, 8'h81}) begin
      n_fail++; $display("FAIL midclr_restart got we=%b a=%h d=%h exp we=1 a=0000 d=81", fb_we, fb_addr, fb_data);
    end
    for (int k = 0; k < 15; k++) tick();
    n_tests++;
    if ({clear_busy, fb_addr} !== {1'b0, 16'h000F}) begin
      n_fail++; $display("FAIL midclr_finish got busy=%b a=%h exp busy=0 a=000f", clear_busy, fb_addr);
    end
  endtask

  task automatic test_vblank();
    do_reset();
    vblank     = 1'b0;
    req1_valid = 1'b1; req1_addr = 16'h1234; req1_data = 8'hC3;
`ifdef FB_VBLANK_ONLY_EN
    for (int k = 0; k < 5; k++) begin
      #1;
      n_tests++;
      if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL vblank_stall[%0d] got %b exp 0", k, req1_ready); end
      tick();
      n_tests++;
      if (fb_we !== 1'b0) begin n_fail++; $display("FAIL vblank_no_write[%0d] got %b exp 0", k, fb_we); end
    end
    vblank = 1'b1;
`endif
    #1;
    n_tests++;
    if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL vblank_grant got %b exp 1", req1_ready); end
    tick();
    req1_valid = 1'b0;
    vblank     = 1'b1;
    n_tests++;
    if ({fb_we, fb_addr, fb_data} !== {1'b1, 16'h1234, 8'hC3}) begin
      n_fail++; $display("FAIL vblank_write got we=%b a=%h d=%h exp we=1 a=1234 d=c3", fb_we, fb_addr, fb_data);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_clear();
    test_reset_mid_clear();
    test_vblank();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fb_write_arbiter.md
# fb_write_arbiter

Shares the single framebuffer write port of the GPU (16-bit address, 8-bit pixel data) between two external requesters, for example the SPI/AVR host loader and a sprite or blit unit. It also contains a built-in clear sequencer that fills a contiguous address range with one value. The block sits between the requesters and the framebuffer RAM write side, in the `clk` domain.

## Interface
Parameters:
- `ADDR_W`, 16, framebuffer address width
- `DATA_W`, 8, pixel data width
- `CLEAR_LAST`, 16'hFFFF, last address written by a clear (the clear range is 0..CLEAR_LAST)

Ports:
- `clk`  in  1  system clock; one clock, all logic on rising edge
- `rst_n`  in  1  reset; synchronous, active-low
- `req0_valid` / `req1_valid`  in  1  requester has a write pending
- `req0_addr` / `req1_addr`  in  ADDR_W  write address
- `req0_data` / `req1_data`  in  DATA_W  write data
- `req0_ready` / `req1_ready`  out  1  grant; a transfer occurs when valid && ready
- `clear_start`  in  1  single-cycle pulse that starts a clear
- `clear_value`  in  DATA_W  fill value, sampled on an accepted `clear_start`
- `clear_busy`  out  1  clear in progress
- `vblank`  in  1  vertical blanking indicator from the VGA timing generator
- `fb_we`  out  1  framebuffer write enable
- `fb_addr`  out  ADDR_W  framebuffer write address
- `fb_data`  out  DATA_W  framebuffer write data

## Operation
- State machine has two states, IDLE and CLEAR.
- IDLE behaviour:
  - Round-robin arbitration between req0 and req1, one grant per cycle at most.
  - `last` pointer records the most recent granted requester. When both requesters are valid, the grant goes to the one that is not `last`. When only one is valid, it is granted.
- Reset behaviour: `last` = 1, so req0 wins the first tie.
- `ready` is combinational and asserts only for the granted requester with valid=1. A requester must hold addr and data stable while valid && !ready.
- IDLE + `clear_start`:
  - Latch `clear_value`, set `cnt` = 0, go to CLEAR next cycle.
  - Requests are still arbitrated normally in the start cycle.
- CLEAR behaviour:
  - Both `ready` outputs are 0.
  - Each eligible cycle writes `cnt` ← latched value, then increments `cnt`.
  - The cycle that writes `cnt` == CLEAR_LAST returns to IDLE.
  - `clear_start` is ignored in CLEAR.
- `clear_busy` = (state == CLEAR).
- `cnt` is ADDR_W bits wide and does not wrap; termination is by compare only.
- The `last` pointer is unchanged by clear writes.

## Timing
- Reset values: `fb_we`=0, `fb_addr`=0, `fb_data`=0, `clear_busy`=0, both `ready`=0 while `rst_n`=0.
- `fb_we`, `fb_addr` and `fb_data` are registered. A handshake or clear write in cycle N appears on the fb port in cycle N+1.
- Throughput is one write per cycle, with back-to-back grants allowed.
- Requester 0xFFFF clear: takes CLEAR_LAST+1 eligible cycles. `clear_busy` rises the cycle after `clear_start` and falls the cycle after the last write is issued.
- Reset mid-clear: next cycle is IDLE with `fb_we`=0. No residual write occurs.
- `fb_addr`/`fb_data` hold their last values when `fb_we`=0.

## Configuration
- Macro `FB_VBLANK_ONLY_EN`.
- Defined: a write (requester grant or clear step) is eligible only when `vblank`=1.
  - With `vblank`=0, both `ready` outputs are 0 and the clear pauses with `cnt` held.
  - `clear_start` is still accepted during active video.
- Undefined: `vblank` is ignored and every cycle is eligible.

## Structure
- Package `fb_pkg` holds:
  - `FB_ADDR_W` and `FB_DATA_W` constants
  - state typedef `fb_arb_state_t` {IDLE, CLEAR}
- Sub-module `rr_arb2`: 2-way round-robin arbiter with inputs `req[1:0]`, `en` and pointer update, output `gnt[1:0]`. It is instantiated once.

## Test plan
- Reset, then req0 valid with addr 0x0010, data 0xA5 → `req0_ready`=1 the same cycle; next cycle `fb_we`=1, `fb_addr`=0x0010, `fb_data`=0xA5.
- req0 and req1 both held valid for 4 cycles → grants follow 0,1,0,1; `fb_addr` alternates between the two addresses; neither ready is asserted twice in a row.
- CLEAR_LAST=15, `clear_start` with `clear_value`=0x3C → 16 writes to addresses 0..15, all data 0x3C; `clear_busy` high for 16 cycles; req0 held valid during the clear is stalled, then granted the cycle after `clear_busy` falls.
- `rst_n` asserted at `cnt`=7 of a clear → next cycle `clear_busy`=0 and `fb_we`=0; a new `clear_start` restarts from address 0.
- With `FB_VBLANK_ONLY_EN`: req1 valid while `vblank`=0 for 5 cycles → `req1_ready`=0 throughout; `vblank` rises → granted that cycle, and the write appears next cycle.
- `clear_start` pulsed again during CLEAR → ignored; total write count stays CLEAR_LAST+1.
